// File: rtl/net_div_arb_pkg.sv
// -----------------------------------------------------------------------------
// net_div_arb_pkg
// Shared types and sizing helpers for the divider arbiter/controller.
//   state_e    : controller FSM states
//   TMO_CW     : timeout counter width for the default timeout
//   cnt_width(): counter width needed to count 0..cyc-1
// -----------------------------------------------------------------------------
package net_div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int TMO_CYC_DFLT = 64;
    localparam int TMO_CW       = $clog2(TMO_CYC_DFLT);

    // Width of a counter that has to reach cyc-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/net_div_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// net_div_arb_rr_arb
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer, wrapping around. Holds no state; the pointer lives in the
// parent.
//   req_i  : request vector
//   ptr_i  : index with highest priority this round
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : binary index of the grant (0 when no request)
// -----------------------------------------------------------------------------
module net_div_arb_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    // Scan from the farthest rotated position down to the pointer so that the
    // last hit written (smallest rotated offset) is the one that sticks.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N_REQ]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + i) % N_REQ] = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/net_div_arb.sv
// -----------------------------------------------------------------------------
// net_div_arb
// Shares one unsigned divider between N_REQ requesters. Requests are granted
// round-robin, one operation in flight at a time. Divide-by-zero is answered
// locally; a divider that never completes is cut off after TMO_CYC cycles.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   req_i, a_i, b_i          : per-requester request level and operands
//   ack_o                    : one-hot pulse, operands of requester k latched
//   res_vld_o                : one-hot pulse, result for requester k
//   quot_o, rem_o            : result, held until the next result
//   dz_o, tmo_o              : divide-by-zero / timeout, valid with res_vld_o
//   busy_o                   : controller not idle
//   div_start_o, div_a_o/b_o : divider start pulse and operands
//   div_ready_i, div_end_i   : divider ready / completion pulse
//   div_quot_i, div_rem_i    : divider results, valid with div_end_i
// -----------------------------------------------------------------------------
module net_div_arb
    import net_div_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int N_REQ   = 4,
    parameter int TMO_CYC = TMO_CYC_DFLT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] a_i,
    input  logic [N_REQ*DW-1:0] b_i,
    output logic [N_REQ-1:0]    ack_o,
    output logic [N_REQ-1:0]    res_vld_o,
    output logic [DW-1:0]       quot_o,
    output logic [DW-1:0]       rem_o,
    output logic                dz_o,
    output logic                tmo_o,
    output logic                busy_o,
    output logic                div_start_o,
    output logic [DW-1:0]       div_a_o,
    output logic [DW-1:0]       div_b_o,
    input  logic                div_ready_i,
    input  logic                div_end_i,
    input  logic [DW-1:0]       div_quot_i,
    input  logic [DW-1:0]       div_rem_i
);

    localparam int IW = cnt_width(N_REQ);
    localparam int TW = cnt_width(TMO_CYC);

    state_e           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [DW-1:0]    r_a, w_a_nxt;
    logic [DW-1:0]    r_b, w_b_nxt;
    logic [TW-1:0]    r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_ack, w_ack_nxt;
    logic [N_REQ-1:0] r_vld, w_vld_nxt;
    logic             r_start, w_start_nxt;
    logic [DW-1:0]    r_quot, w_quot_nxt;
    logic [DW-1:0]    r_rem, w_rem_nxt;
    logic             r_dz, w_dz_nxt;
    logic             r_tmo, w_tmo_nxt;

    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_idx;
    logic [DW-1:0]    w_win_a;
    logic [DW-1:0]    w_win_b;

    net_div_arb_rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arb (
        .req_i (req_i),
        .ptr_i (r_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_idx)
    );

    assign w_win_a = a_i[int'(w_idx)*DW +: DW];
    assign w_win_b = b_i[int'(w_idx)*DW +: DW];

    // Next-state and next-register values. Pulse outputs default low, the
    // result registers default to holding.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = '0;
        w_vld_nxt   = '0;
        w_start_nxt = 1'b0;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dz_nxt    = 1'b0;
        w_tmo_nxt   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (|req_i && div_ready_i) begin
                    w_gnt_nxt   = w_gnt;
                    w_idx_nxt   = w_idx;
                    w_a_nxt     = w_win_a;
                    w_b_nxt     = w_win_b;
                    // ack and start are registered, so they are set on the
                    // way into ISSUE and appear during the ISSUE cycle.
                    w_ack_nxt   = w_gnt;
                    w_start_nxt = (w_win_b != '0);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_b == '0) begin
                    w_quot_nxt  = '1;
                    w_rem_nxt   = r_a;
                    w_dz_nxt    = 1'b1;
                    w_vld_nxt   = r_gnt;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the last counted cycle still wins over the
                // timeout.
                if (div_end_i) begin
                    w_quot_nxt  = div_quot_i;
                    w_rem_nxt   = div_rem_i;
                    w_vld_nxt   = r_gnt;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == TW'(TMO_CYC - 1)) begin
                    w_quot_nxt  = '0;
                    w_rem_nxt   = '0;
                    w_tmo_nxt   = 1'b1;
                    w_vld_nxt   = r_gnt;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_ptr_nxt   = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_vld   <= '0;
            r_start <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_vld   <= w_vld_nxt;
            r_start <= w_start_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dz    <= w_dz_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign ack_o       = r_ack;
    assign res_vld_o   = r_vld;
    assign quot_o      = r_quot;
    assign rem_o       = r_rem;
    assign dz_o        = r_dz;
    assign tmo_o       = r_tmo;
    assign busy_o      = (r_state != ST_IDLE);
    assign div_start_o = r_start;
    assign div_a_o     = r_a;
    assign div_b_o     = r_b;

endmodule

// File: tb/tb_net_div_arb.sv
module tb_net_div_arb;

    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N*DW-1:0] a_i, b_i;
    logic [N-1:0]    ack_o, res_vld_o;
    logic [DW-1:0]   quot_o, rem_o, div_a_o, div_b_o;
    logic            dz_o, tmo_o, busy_o, div_start_o;
    logic            div_ready_i, div_end_i;
    logic [DW-1:0]   div_quot_i, div_rem_i;

    logic [DW-1:0]   op_a [N];
    logic [DW-1:0]   op_b [N];

    int n_err = 0;
    int n_chk = 0;
    int m_ptr = 0;

    // divider stub
    int   st_lat  = 4;
    bit   st_hang = 1'b0;
    logic tb_end  = 1'b0;
    logic st_end  = 1'b0;
    logic st_busy = 1'b0;
    int   st_cnt  = 0;

    always #5 clk = ~clk;

    net_div_arb #(.DW(DW), .N_REQ(N), .TMO_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .a_i(a_i), .b_i(b_i),
        .ack_o(ack_o), .res_vld_o(res_vld_o), .quot_o(quot_o), .rem_o(rem_o),
        .dz_o(dz_o), .tmo_o(tmo_o), .busy_o(busy_o), .div_start_o(div_start_o),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_ready_i(div_ready_i),
        .div_end_i(div_end_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i)
    );

    always_comb begin
        a_i = '0;
        b_i = '0;
        for (int k = 0; k < N; k++) begin
            a_i[k*DW +: DW] = op_a[k];
            b_i[k*DW +: DW] = op_b[k];
        end
    end

    // Fixed-latency divider: end pulse st_lat cycles after the start cycle.
    always @(posedge clk) begin
        st_end <= 1'b0;
        if (div_start_o && !st_hang) begin
            div_quot_i <= (div_b_o == 0) ? '1 : div_a_o / div_b_o;
            div_rem_i  <= (div_b_o == 0) ? div_a_o : div_a_o % div_b_o;
            if (st_lat <= 1) st_end <= 1'b1;
            else begin
                st_busy <= 1'b1;
                st_cnt  <= st_lat - 1;
            end
        end else if (st_busy) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) begin
                st_end  <= 1'b1;
                st_busy <= 1'b0;
            end
        end
    end
    assign div_end_i = st_end | tb_end;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0 && k < N) v[k] = 1'b1;
        return v;
    endfunction

    // Issue one request (DUT must be idle, called at a negedge); checks grant,
    // start, result timing and flags against the rotating-priority model.
    task automatic serve(input logic [N-1:0] req, input int lat, input bit hang, input bit hold,
                         output int g, output logic [DW-1:0] q, output logic [DW-1:0] r);
        int eg, elat, n;
        logic [DW-1:0] bw;
        eg = 0;
        for (int i = 0; i < N; i++) begin
            if (req[(m_ptr + i) % N]) begin
                eg = (m_ptr + i) % N;
                break;
            end
        end
        st_lat  = lat;
        st_hang = hang;
        check("idle_before_req", busy_o, 0);
        req_i = req;
        @(negedge clk);
        check("ack", ack_o, onehot(eg));
        bw = op_b[eg];
        check("div_start", div_start_o, bw != 0);
        if (bw != 0) check("div_b", div_b_o, bw);
        if (!hold) req_i[eg] = 1'b0;
        elat = (bw == 0) ? 1 : (hang ? TMO + 1 : lat + 1);
        n = 0;
        while (res_vld_o == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("res_vld", res_vld_o, onehot(eg));
        check("latency", n, elat);
        check("dz", dz_o, bw == 0);
        check("tmo", tmo_o, hang && bw != 0);
        g = eg;
        q = quot_o;
        r = rem_o;
        m_ptr = (eg + 1) % N;
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [DW-1:0] a, b, eq, er;
    } vec_t;

    initial begin
        vec_t vt [8];
        int g, bad;
        logic [DW-1:0] q, r, ea, eb, eq, er;
        int exp_g [5] = '{0, 1, 2, 3, 0};

        vt[0] = '{4'b0001, 32'd100,        32'd7,          32'd14,         32'd2};
        vt[1] = '{4'b0100, 32'd55,         32'd0,          32'hFFFF_FFFF,  32'd55};
        vt[2] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vt[3] = '{4'b1000, 32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5};
        vt[4] = '{4'b0001, 32'd0,          32'd9,          32'd0,          32'd0};
        vt[5] = '{4'b1001, 32'd1000,       32'd10,         32'd100,        32'd0};
        vt[6] = '{4'b0010, 32'd7,          32'd7,          32'd1,          32'd0};
        vt[7] = '{4'b0001, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};

        rst_i = 1'b1;
        req_i = '0;
        div_ready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ack", ack_o, 0);
        check("rst_vld", res_vld_o, 0);
        check("rst_quot_rem", {quot_o, rem_o}, 0);
        check("rst_flags", {dz_o, tmo_o, busy_o, div_start_o}, 0);
        check("rst_div_ops", {div_a_o, div_b_o}, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // round-robin with all requests held
        for (int k = 0; k < N; k++) begin
            op_a[k] = 32'd10;
            op_b[k] = 32'd3;
        end
        for (int i = 0; i < 5; i++) begin
            serve(4'b1111, 4, 1'b0, 1'b1, g, q, r);
            check("rr_order", g, exp_g[i]);
            check("rr_result", {q, r}, {32'd3, 32'd1});
        end
        req_i = '0;
        @(negedge clk);

        // table vectors: every requester presents the same operands
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                op_a[k] = vt[i].a;
                op_b[k] = vt[i].b;
            end
            serve(vt[i].req, 4, 1'b0, 1'b0, g, q, r);
            check("tbl_quot", q, vt[i].eq);
            check("tbl_rem", r, vt[i].er);
        end

        // not ready: request must wait
        div_ready_i = 1'b0;
        req_i = 4'b0001;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack_o != 0 || busy_o) bad++;
        end
        check("no_grant_when_not_ready", bad, 0);
        req_i = '0;
        div_ready_i = 1'b1;
        op_a[0] = 32'd9;
        op_b[0] = 32'd4;
        serve(4'b0001, 2, 1'b0, 1'b0, g, q, r);
        check("after_ready", {q, r}, {32'd2, 32'd1});

        // timeout, then a late completion must be ignored
        op_a[1] = 32'd77;
        op_b[1] = 32'd3;
        serve(4'b0010, 4, 1'b1, 1'b0, g, q, r);
        check("tmo_result", {q, r}, 0);
        tb_end = 1'b1;
        @(negedge clk);
        tb_end = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (res_vld_o != 0 || busy_o) bad++;
        end
        check("late_end_ignored", bad, 0);
        st_hang = 1'b0;

        // reset in WAIT; the stale completion must produce nothing
        op_a[2] = 32'd50;
        op_b[2] = 32'd5;
        st_lat = 10;
        req_i = 4'b0100;
        @(negedge clk);
        check("mid_ack", ack_o, 4'b0100);
        req_i = '0;
        repeat (2) @(negedge clk);
        check("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("mid_rst_outs", {ack_o, res_vld_o, dz_o, tmo_o, busy_o, div_start_o}, 0);
        check("mid_rst_data", {quot_o, rem_o, div_a_o}, 0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_vld_o != 0 || busy_o) bad++;
        end
        check("stale_end_ignored", bad, 0);
        m_ptr = 0;
        for (int k = 0; k < N; k++) begin
            op_a[k] = 32'd20 + k;
            op_b[k] = 32'd6;
        end
        serve(4'b1111, 3, 1'b0, 1'b0, g, q, r);
        check("ptr_after_rst", g, 0);
        check("ptr_after_rst_res", {q, r}, {32'd3, 32'd2});

        // randomized operations vs. plain arithmetic
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                op_a[k] = $urandom;
                if ($urandom_range(0, 4) == 0) op_b[k] = '0;
                else if ($urandom_range(0, 1) == 1) op_b[k] = $urandom;
                else op_b[k] = $urandom_range(1, 20);
            end
            serve(4'($urandom_range(1, 15)), $urandom_range(1, 10), 1'b0, 1'b0, g, q, r);
            ea = op_a[g];
            eb = op_b[g];
            eq = (eb == 0) ? '1 : ea / eb;
            er = (eb == 0) ? ea : ea % eb;
            check("rnd_quot", q, eq);
            check("rnd_rem", r, er);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
